// File: rtl/ula_div_pkg.sv
// Shared constants and state encoding for the ULA divider datapath.
// Imported by the sequenced divider and its restoring stage.
package ula_div_pkg;

  localparam int N_BITS    = 8;
  localparam int DIV_ITERS = 8;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

  // Wide NOR: true when every bit of the operand is clear.
  function automatic logic is_zero(input logic [N_BITS-1:0] v);
    return ~|v;
  endfunction

endpackage

// File: rtl/estdiv.sv
// One restoring-division stage: trial-subtracts B from A and restores on borrow.
// Qbit is the borrow out, so the quotient bit is its inverse.
module estdiv
  import ula_div_pkg::*;
(
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  output logic [N_BITS-1:0] Rs,
  output logic              Qbit
);

  logic [N_BITS:0]   borrow;
  logic [N_BITS-1:0] diff;

  assign borrow[0] = 1'b0;

  // Ripple full-subtractor chain followed by the restore mux on each bit.
  generate
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_sub
      assign diff[gi]       = A[gi] ^ B[gi] ^ borrow[gi];
      assign borrow[gi + 1] = (~A[gi] & B[gi]) | (~(A[gi] ^ B[gi]) & borrow[gi]);
      assign Rs[gi]         = borrow[N_BITS] ? A[gi] : diff[gi];
    end
  endgenerate

  assign Qbit = borrow[N_BITS];

endmodule

// File: rtl/divisor_seq_ctrl.sv
// Sequenced restoring divider: one estdiv stage reused over DIV_ITERS cycles,
// with a start/busy/done handshake and registered results.
module divisor_seq_ctrl
  import ula_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_BITS-1:0] A,
  input  logic [N_BITS-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] S,
  output logic [N_BITS-1:0] R,
  output logic              R_exists,
  output logic              ERRO
);

  div_state_t        state;
  logic [N_BITS-1:0] dvd_q;
  logic [N_BITS-1:0] dvs_q;
  logic [N_BITS-1:0] rem_q;
  logic [CNT_W-1:0]  cnt;

  logic [N_BITS-1:0] stage_in;
  logic [N_BITS-1:0] stage_rs;
  logic              stage_qbit;
  logic [N_BITS-1:0] dvd_shift;
  logic              dvs_zero;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign stage_in  = {rem_q[N_BITS-2:0], dvd_q[N_BITS-1]};
  assign dvd_shift = {dvd_q[N_BITS-2:0], ~stage_qbit};
  assign dvs_zero  = is_zero(B);

  estdiv u_estdiv (
    .A    (stage_in),
    .B    (dvs_q),
    .Rs   (stage_rs),
    .Qbit (stage_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      S        <= '0;
      R        <= '0;
      R_exists <= 1'b0;
      ERRO     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_q <= A;
            dvs_q <= B;
            rem_q <= '0;
            cnt   <= CNT_LOAD;
            if (dvs_zero) begin
              // Divide-by-zero skips RUN and reports straight away.
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              S        <= '0;
              R        <= '0;
              R_exists <= 1'b0;
              ERRO     <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          rem_q <= stage_rs;
          dvd_q <= dvd_shift;
          if (cnt == '0) begin
            // Results are loaded on the edge into DONE so they are valid with done.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            S        <= dvd_shift;
            R        <= stage_rs;
            R_exists <= |stage_rs;
            ERRO     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/divisor_seq_ctrl.md
# divisor_seq_ctrl

Multi-cycle sequencer for the ULA's restoring divider. It time-multiplexes one `estdiv` restoring stage over 8 clock cycles instead of cascading 8 stages combinationally. A start/busy/done handshake connects it to the ULA operation controller. It produces the same quotient, remainder-flag and divide-by-zero results as the combinational `divisor`, plus the full remainder.

## Interface
- `N_BITS`, 8: operand width; fixed at 8, because the `estdiv` stage is 8-bit.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `A`  in  8  dividend; captured on the accepting edge.
- `B`  in  8  divisor; captured on the accepting edge.
- `busy`  out  1  high while an operation is in RUN.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `S`  out  8  quotient.
- `R`  out  8  remainder.
- `R_exists`  out  1  high when R != 0 and there is no error.
- `ERRO`  out  1  divide-by-zero flag.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `start`=1 latches A into `dvd_q` and B into `dvs_q`, clears `rem_q`, and loads the iteration counter `cnt`=7.
  - If B==0, the next state is DONE with the error path. Otherwise the next state is RUN.
- RUN: one iteration per cycle.
  - The stage input is {rem_q[6:0], dvd_q[7]}, applied with `dvs_q` to `estdiv`.
  - `rem_q` loads the stage's Rs output.
  - `dvd_q` shifts left, and inverted Qbit enters at bit 0.
  - When `cnt`==0, go to DONE. Otherwise decrement `cnt`.
- DONE:
  - `done`=1 for this cycle only.
  - Output registers load: S=dvd_q, R=rem_q, R_exists=|rem_q, ERRO=0.
  - On the error path they load S=0, R=0, R_exists=0, ERRO=1.
  - With `start`=1, accept the new operands exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- `start` in RUN is ignored. The operand registers are not disturbed.
- Output registers S, R, R_exists and ERRO hold their values until the next completion. They do not clear on a new start.
- Arithmetic is unsigned 8-bit. S and R satisfy A = S*B + R with R < B.

## Timing
- All outputs are registered.
- Reset values: every output is 0 (busy, done, S, R, R_exists, ERRO). Internal registers are 0 and the state is IDLE.
- `rst_n` low at any time, including mid-RUN, aborts the operation immediately and asynchronously. No `done` is produced. Outputs return to 0.
- Normal latency, with `start` accepted on the edge ending cycle 0:
  - Cycles 1–8 are RUN with `busy`=1.
  - Cycle 9 is DONE with `done`=1, and S/R/flags are valid.
- Divide-by-zero latency: cycle 1 is DONE with `done`=1 and ERRO=1. `busy` never asserts.
- Back-to-back throughput is one result per 9 cycles (DONE overlaps acceptance).
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package `ula_div_pkg` holds:
  - `N_BITS`=8
  - `DIV_ITERS`=8
  - the state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10
- Sub-module: one instance of the existing `estdiv` restoring stage. No other hierarchy.
- The B==0 detect is an 8-input NOR on the captured operand bus, as in `divisor`.

## Test plan
- A=100, B=7, pulse `start` → `busy` high for 8 cycles, then `done` in cycle 9 with S=14, R=2, R_exists=1, ERRO=0.
- A=255, B=1 → S=255, R=0, R_exists=0. A=0, B=3 → S=0, R=0, R_exists=0.
- A=5, B=0 → `done` in cycle 1 with ERRO=1, S=0, R=0, R_exists=0. `busy` stays 0.
- A=200, B=9 started. In cycle 4, drive `start`=1 with A=1, B=1 → ignored. Result at cycle 9 is S=22, R=2.
- `start` held high in the DONE cycle of 100/7 with new operands A=17, B=17 → second `done` 9 cycles later with S=1, R=0. The first result stays visible meanwhile.
- Assert `rst_n`=0 in cycle 5 of 100/7, release, then start 9/4 → all outputs 0 during reset, no `done` from the aborted operation, then S=2, R=1, R_exists=1.
